// File: rtl/riscv_core_amo_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : riscv_core_amo_unit
// Description : Execute-stage sequencer for RISC-V A-extension instructions.
//               Runs AMO read-modify-write, LR and SC sequences over a
//               single-outstanding data-memory port. It stalls the pipeline
//               while busy, pulses done with the rd value, and owns the LR/SC
//               reservation register.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_amo_unit_clk          core clock
//   i_amo_unit_rst_n        asynchronous active-low reset
//   i_amo_unit_valid        start request, sampled only in IDLE
//   i_amo_unit_amo          read-modify-write AMO
//   i_amo_unit_amo_op       0 swap,1 add,2 and,3 or,4 xor,5 max,6 min,7 maxu,8 minu
//   i_amo_unit_lr           load-reserved
//   i_amo_unit_sc           store-conditional
//   i_amo_unit_size         2'b10 word, 2'b11 doubleword
//   i_amo_unit_addr         rs1 value (effective address)
//   i_amo_unit_rs2          rs2 value
//   i_amo_unit_resv_clr     invalidate the reservation
//   i_amo_unit_mem_ready    memory accepts/completes the current request
//   i_amo_unit_mem_rdata    read data, valid with ready on a read
//   o_amo_unit_mem_req      memory request
//   o_amo_unit_mem_we       1 = write
//   o_amo_unit_mem_addr     request address
//   o_amo_unit_mem_wdata    write data (word ops in bits [31:0])
//   o_amo_unit_mem_size     latched access size
//   o_amo_unit_busy         pipeline stall
//   o_amo_unit_done         one-cycle completion pulse
//   o_amo_unit_result       rd writeback value, valid with done
//   o_amo_unit_misaligned   address-misaligned exception, pulses with done
// ============================================================================
module riscv_core_amo_unit #(
  parameter int XLEN = 64
) (
  input  logic            i_amo_unit_clk,
  input  logic            i_amo_unit_rst_n,
  input  logic            i_amo_unit_valid,
  input  logic            i_amo_unit_amo,
  input  logic [3:0]      i_amo_unit_amo_op,
  input  logic            i_amo_unit_lr,
  input  logic            i_amo_unit_sc,
  input  logic [1:0]      i_amo_unit_size,
  input  logic [XLEN-1:0] i_amo_unit_addr,
  input  logic [XLEN-1:0] i_amo_unit_rs2,
  input  logic            i_amo_unit_resv_clr,
  input  logic            i_amo_unit_mem_ready,
  input  logic [XLEN-1:0] i_amo_unit_mem_rdata,
  output logic            o_amo_unit_mem_req,
  output logic            o_amo_unit_mem_we,
  output logic [XLEN-1:0] o_amo_unit_mem_addr,
  output logic [XLEN-1:0] o_amo_unit_mem_wdata,
  output logic [1:0]      o_amo_unit_mem_size,
  output logic            o_amo_unit_busy,
  output logic            o_amo_unit_done,
  output logic [XLEN-1:0] o_amo_unit_result,
  output logic            o_amo_unit_misaligned
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] C_OP_SWAP = 4'd0;
  localparam logic [3:0] C_OP_ADD  = 4'd1;
  localparam logic [3:0] C_OP_AND  = 4'd2;
  localparam logic [3:0] C_OP_OR   = 4'd3;
  localparam logic [3:0] C_OP_XOR  = 4'd4;
  localparam logic [3:0] C_OP_MAX  = 4'd5;
  localparam logic [3:0] C_OP_MIN  = 4'd6;
  localparam logic [3:0] C_OP_MAXU = 4'd7;
  localparam logic [3:0] C_OP_MINU = 4'd8;

  localparam logic [1:0]      C_SIZE_D    = 2'b11;
  localparam logic [XLEN-1:0] C_WORD_MASK = XLEN'(64'h0000_0000_FFFF_FFFF);

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_is_lr;
  logic [3:0]      r_amo_op;
  logic [1:0]      r_size;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_result;
  logic            r_misaligned;
  logic            r_resv_valid;
  logic [XLEN-1:0] r_resv_addr;

  // --------------------------------------------------------------------------
  // Start-of-operation decode (IDLE only)
  // --------------------------------------------------------------------------
  logic w_in_word;
  logic w_in_misaligned;
  logic w_in_any_op;
  logic w_sc_hit;

  assign w_in_word       = (i_amo_unit_size != C_SIZE_D);
  assign w_in_misaligned = w_in_word ? (|i_amo_unit_addr[1:0]) : (|i_amo_unit_addr[2:0]);
  assign w_in_any_op     = i_amo_unit_amo | i_amo_unit_lr | i_amo_unit_sc;
  // A clear arriving in the same cycle as the SC is honoured: the SC fails.
  assign w_sc_hit        = r_resv_valid && !i_amo_unit_resv_clr &&
                           (r_resv_addr == i_amo_unit_addr);

  // --------------------------------------------------------------------------
  // Load value and modify datapath (latched operation)
  // --------------------------------------------------------------------------
  logic            w_word;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_opb;
  logic [XLEN-1:0] w_mod;
  logic [XLEN-1:0] w_mod_wdata;
  logic            w_lt_s;
  logic            w_lt_u;

  assign w_word = (r_size != C_SIZE_D);
  // Both operands are sign-extended for word ops: this keeps the 64-bit signed
  // compare equal to a 32-bit signed compare, and since sign extension is
  // monotonic in unsigned order the unsigned compare stays correct as well.
  assign w_load = w_word ? XLEN'($signed(i_amo_unit_mem_rdata[31:0])) : i_amo_unit_mem_rdata;
  assign w_opb  = w_word ? XLEN'($signed(r_rs2[31:0])) : r_rs2;
  assign w_lt_s = ($signed(w_load) < $signed(w_opb));
  assign w_lt_u = (w_load < w_opb);

  always_comb begin
    w_mod = w_load;
    case (r_amo_op)
      C_OP_SWAP: w_mod = w_opb;
      C_OP_ADD:  w_mod = w_load + w_opb;
      C_OP_AND:  w_mod = w_load & w_opb;
      C_OP_OR:   w_mod = w_load | w_opb;
      C_OP_XOR:  w_mod = w_load ^ w_opb;
      C_OP_MAX:  w_mod = w_lt_s ? w_opb  : w_load;
      C_OP_MIN:  w_mod = w_lt_s ? w_load : w_opb;
      C_OP_MAXU: w_mod = w_lt_u ? w_opb  : w_load;
      C_OP_MINU: w_mod = w_lt_u ? w_load : w_opb;
      default:   w_mod = w_load;
    endcase
  end

  assign w_mod_wdata = w_word ? (w_mod & C_WORD_MASK) : w_mod;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_amo_unit_clk or negedge i_amo_unit_rst_n) begin
    if (!i_amo_unit_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_amo_unit_valid) begin
          if (!w_in_any_op || w_in_misaligned) begin
            w_state_nxt = ST_DONE;
          end else if (i_amo_unit_amo || i_amo_unit_lr) begin
            w_state_nxt = ST_RD;
          end else if (w_sc_hit) begin
            w_state_nxt = ST_WR;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_RD: begin
        if (i_amo_unit_mem_ready) begin
          w_state_nxt = r_is_lr ? ST_DONE : ST_WR;
        end
      end
      ST_WR: begin
        if (i_amo_unit_mem_ready) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operation latches, result, write data and reservation
  // --------------------------------------------------------------------------
  always_ff @(posedge i_amo_unit_clk or negedge i_amo_unit_rst_n) begin
    if (!i_amo_unit_rst_n) begin
      r_is_lr      <= 1'b0;
      r_amo_op     <= 4'd0;
      r_size       <= 2'd0;
      r_addr       <= '0;
      r_rs2        <= '0;
      r_wdata      <= '0;
      r_result     <= '0;
      r_misaligned <= 1'b0;
      r_resv_valid <= 1'b0;
      r_resv_addr  <= '0;
    end else begin
      // Later assignments in this block that set the reservation are gated by
      // resv_clr, so a coincident clear always wins.
      if (i_amo_unit_resv_clr) begin
        r_resv_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_amo_unit_valid) begin
            r_is_lr      <= i_amo_unit_lr & ~i_amo_unit_amo;
            r_amo_op     <= i_amo_unit_amo_op;
            r_size       <= i_amo_unit_size;
            r_addr       <= i_amo_unit_addr;
            r_rs2        <= i_amo_unit_rs2;
            r_result     <= '0;
            r_misaligned <= 1'b0;
            if (w_in_any_op && w_in_misaligned) begin
              r_misaligned <= 1'b1;
            end else if (i_amo_unit_sc && !i_amo_unit_amo && !i_amo_unit_lr) begin
              // Any aligned SC consumes the reservation, pass or fail.
              r_resv_valid <= 1'b0;
              if (w_sc_hit) begin
                r_wdata <= w_in_word ? (i_amo_unit_rs2 & C_WORD_MASK) : i_amo_unit_rs2;
              end else begin
                r_result <= XLEN'(1);
              end
            end
          end
        end
        ST_RD: begin
          if (i_amo_unit_mem_ready) begin
            r_result <= w_load;
            if (r_is_lr) begin
              if (!i_amo_unit_resv_clr) begin
                r_resv_valid <= 1'b1;
                r_resv_addr  <= r_addr;
              end
            end else begin
              r_wdata <= w_mod_wdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_amo_unit_mem_req    = (r_state == ST_RD) || (r_state == ST_WR);
  assign o_amo_unit_mem_we     = (r_state == ST_WR);
  assign o_amo_unit_mem_addr   = r_addr;
  assign o_amo_unit_mem_wdata  = r_wdata;
  assign o_amo_unit_mem_size   = r_size;
  assign o_amo_unit_busy       = (r_state != ST_IDLE);
  assign o_amo_unit_done       = (r_state == ST_DONE);
  assign o_amo_unit_result     = (r_state == ST_DONE) ? r_result : '0;
  assign o_amo_unit_misaligned = (r_state == ST_DONE) && r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_amo_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_riscv_core_amo_unit
// Description : Table-driven bench for riscv_core_amo_unit with a small memory
//               responder, plus hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_core_amo_unit;

  localparam int XLEN = 64;

  localparam logic [3:0] SWAP = 4'd0, ADD = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4;
  localparam logic [3:0] MAX = 4'd5, MIN = 4'd6, MAXU = 4'd7, MINU = 4'd8;
  localparam logic [1:0] W = 2'b10, D = 2'b11;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid = 1'b0;
  logic            amo = 1'b0;
  logic [3:0]      amo_op = 4'd0;
  logic            lr = 1'b0;
  logic            sc = 1'b0;
  logic [1:0]      size = 2'b11;
  logic [XLEN-1:0] addr = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            resv_clr = 1'b0;
  logic            mem_ready = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [1:0]      mem_size;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            misaligned;

  always #5 clk = ~clk;

  riscv_core_amo_unit #(.XLEN(XLEN)) dut (
    .i_amo_unit_clk        (clk),
    .i_amo_unit_rst_n      (rst_n),
    .i_amo_unit_valid      (valid),
    .i_amo_unit_amo        (amo),
    .i_amo_unit_amo_op     (amo_op),
    .i_amo_unit_lr         (lr),
    .i_amo_unit_sc         (sc),
    .i_amo_unit_size       (size),
    .i_amo_unit_addr       (addr),
    .i_amo_unit_rs2        (rs2),
    .i_amo_unit_resv_clr   (resv_clr),
    .i_amo_unit_mem_ready  (mem_ready),
    .i_amo_unit_mem_rdata  (mem_rdata),
    .o_amo_unit_mem_req    (mem_req),
    .o_amo_unit_mem_we     (mem_we),
    .o_amo_unit_mem_addr   (mem_addr),
    .o_amo_unit_mem_wdata  (mem_wdata),
    .o_amo_unit_mem_size   (mem_size),
    .o_amo_unit_busy       (busy),
    .o_amo_unit_done       (done),
    .o_amo_unit_result     (result),
    .o_amo_unit_misaligned (misaligned)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mem [logic [63:0]];

  typedef struct {
    string       name;
    logic        amo;
    logic [3:0]  op;
    logic        lr;
    logic        sc;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] rs2;
    logic [63:0] mem_init;
    int          rd_wait;
    int          wr_wait;
    logic        clr;
    logic        pre_clr;
    logic        keep_valid;
    logic [63:0] exp_result;
    logic [63:0] exp_wdata;
    logic        exp_mis;
    int          exp_cyc;
    int          exp_nrd;
    int          exp_nwr;
  } vec_t;

  typedef struct {
    int          done_cyc;
    logic [63:0] result;
    logic        mis;
    int          n_rd;
    int          n_wr;
    logic [63:0] rd_addr;
    logic [63:0] wr_addr;
    logic [63:0] wdata;
    logic        hs_ok;
    logic        timeout;
  } res_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return 64'h0;
  endfunction

  function automatic vec_t mk(input string name, input logic a, input logic [3:0] op,
                              input logic l, input logic s, input logic [1:0] sz,
                              input logic [63:0] ad, input logic [63:0] r2,
                              input logic [63:0] mi, input logic [63:0] er,
                              input logic [63:0] ew, input logic em,
                              input int ec, input int nrd, input int nwr);
    vec_t v;
    v.name = name; v.amo = a; v.op = op; v.lr = l; v.sc = s; v.size = sz;
    v.addr = ad; v.rs2 = r2; v.mem_init = mi;
    v.rd_wait = 0; v.wr_wait = 0; v.clr = 1'b0; v.pre_clr = 1'b0; v.keep_valid = 1'b0;
    v.exp_result = er; v.exp_wdata = ew; v.exp_mis = em;
    v.exp_cyc = ec; v.exp_nrd = nrd; v.exp_nwr = nwr;
    return v;
  endfunction

  // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input vec_t v, output res_t r);
    logic [63:0] cap_addr, cap_wdata, tmp;
    logic        cap_we, prev_req, prev_ready, done_seen;
    int          rdw, wrw, cyc;
    r.done_cyc = 0; r.result = '0; r.mis = 1'b0; r.n_rd = 0; r.n_wr = 0;
    r.rd_addr = '0; r.wr_addr = '0; r.wdata = '0; r.hs_ok = 1'b1; r.timeout = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
    if (v.pre_clr) begin
      resv_clr = 1'b1;
      @(negedge clk);
      resv_clr = 1'b0;
    end
    if (v.amo || v.lr) mem[v.addr] = v.mem_init;
    valid = 1'b1; amo = v.amo; amo_op = v.op; lr = v.lr; sc = v.sc;
    size = v.size; addr = v.addr; rs2 = v.rs2; resv_clr = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    cyc = 0; rdw = 0; wrw = 0; prev_req = 1'b0; prev_ready = 1'b0; done_seen = 1'b0;
    while (!done_seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!v.keep_valid) valid = 1'b0;
      resv_clr = v.clr;
      mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      if (done) begin
        done_seen = 1'b1;
        r.done_cyc = cyc; r.result = result; r.mis = misaligned;
        mem_ready = 1'b0; valid = 1'b0; resv_clr = 1'b0;
      end else begin
        if (!busy) r.hs_ok = 1'b0;
        if (mem_req) begin
          if (prev_req && !prev_ready && (mem_we == cap_we)) begin
            if (mem_addr !== cap_addr || mem_wdata !== cap_wdata) r.hs_ok = 1'b0;
          end
          cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we;
          if (mem_size !== v.size) r.hs_ok = 1'b0;
          if (!mem_we) begin
            if (rdw < v.rd_wait) begin
              mem_ready = 1'b0; rdw++;
            end else begin
              mem_ready = 1'b1; mem_rdata = mem_rd(mem_addr);
              r.n_rd++; r.rd_addr = mem_addr;
            end
          end else begin
            if (wrw < v.wr_wait) begin
              mem_ready = 1'b0; wrw++;
            end else begin
              mem_ready = 1'b1; r.n_wr++; r.wr_addr = mem_addr; r.wdata = mem_wdata;
              tmp = mem_rd(mem_addr);
              if (v.size == D) mem[mem_addr] = mem_wdata;
              else mem[mem_addr] = {tmp[63:32], mem_wdata[31:0]};
            end
          end
        end else begin
          mem_ready = 1'b0;
        end
        prev_req = mem_req; prev_ready = mem_ready;
      end
    end
    r.timeout = !done_seen;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; mem_ready = 1'b0; resv_clr = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input res_t r);
    check({v.name, ".timeout"}, r.timeout, 1'b0);
    check({v.name, ".result"}, r.result, v.exp_result);
    check({v.name, ".misaligned"}, r.mis, v.exp_mis);
    check({v.name, ".done_cycle"}, r.done_cyc, v.exp_cyc);
    check({v.name, ".reads"}, r.n_rd, v.exp_nrd);
    check({v.name, ".writes"}, r.n_wr, v.exp_nwr);
    check({v.name, ".handshake"}, r.hs_ok, 1'b1);
    if (v.exp_nrd > 0) check({v.name, ".rd_addr"}, r.rd_addr, v.addr);
    if (v.exp_nwr > 0) begin
      check({v.name, ".wr_addr"}, r.wr_addr, v.addr);
      check({v.name, ".wdata"}, r.wdata, v.exp_wdata);
    end
    check({v.name, ".idle_after"}, busy, 1'b0);
  endtask

  initial begin
    vec_t v;
    res_t r;

    // name amo op lr sc size addr rs2 mem_init exp_result exp_wdata mis cyc nrd nwr
    vecs.push_back(mk("amoadd_d", 1, ADD, 0, 0, D, 64'h1000, 64'h3, 64'h5, 64'h5, 64'h8, 0, 3, 1, 1));
    vecs.push_back(mk("amomin_w", 1, MIN, 0, 0, W, 64'h1100, 64'h1, 64'hFFFF_FFFF,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF, 0, 3, 1, 1));
    vecs.push_back(mk("amominu_w", 1, MINU, 0, 0, W, 64'h1200, 64'h1, 64'hFFFF_FFFF,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 3, 1, 1));
    vecs.push_back(mk("amomax_d", 1, MAX, 0, 0, D, 64'h1300, 64'h5, 64'h8000_0000_0000_0000,
                      64'h8000_0000_0000_0000, 64'h5, 0, 3, 1, 1));
    vecs.push_back(mk("amomaxu_d", 1, MAXU, 0, 0, D, 64'h1308, 64'h5, 64'h8000_0000_0000_0000,
                      64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 3, 1, 1));
    vecs.push_back(mk("amoxor_w", 1, XOR, 0, 0, W, 64'h1400, 64'hFFFF_FFFF_00FF_00FF, 64'h0F0F_0F0F,
                      64'h0F0F_0F0F, 64'h0FF0_0FF0, 0, 3, 1, 1));
    vecs.push_back(mk("amoand_d", 1, AND, 0, 0, D, 64'h1500, 64'hFF00, 64'hF0F0, 64'hF0F0, 64'hF000, 0, 3, 1, 1));
    vecs.push_back(mk("amoswap_w", 1, SWAP, 0, 0, W, 64'h1604, 64'h1234_5678, 64'h8000_0000,
                      64'hFFFF_FFFF_8000_0000, 64'h1234_5678, 0, 3, 1, 1));
    vecs.push_back(mk("amoadd_w_wrap", 1, ADD, 0, 0, W, 64'h1700, 64'h2, 64'hFFFF_FFFF,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 3, 1, 1));
    vecs.push_back(mk("amoswap_d_mis", 1, SWAP, 0, 0, D, 64'h1004, 64'h9, 64'h0, 64'h0, 64'h0, 1, 1, 0, 0));
    vecs.push_back(mk("amoadd_w_mis", 1, ADD, 0, 0, W, 64'h1702, 64'h9, 64'h0, 64'h0, 64'h0, 1, 1, 0, 0));
    vecs.push_back(mk("no_op", 0, ADD, 0, 0, D, 64'h1001, 64'h9, 64'h0, 64'h0, 64'h0, 0, 1, 0, 0));
    vecs.push_back(mk("lr_d", 0, SWAP, 1, 0, D, 64'h2000, 64'h0, 64'h77, 64'h77, 64'h0, 0, 2, 1, 0));
    vecs.push_back(mk("sc_d_ok", 0, SWAP, 0, 1, D, 64'h2000, 64'hAB, 64'h0, 64'h0, 64'hAB, 0, 2, 0, 1));
    vecs.push_back(mk("sc_d_again", 0, SWAP, 0, 1, D, 64'h2000, 64'hCD, 64'h0, 64'h1, 64'h0, 0, 1, 0, 0));
    vecs.push_back(mk("lr_d_2100", 0, SWAP, 1, 0, D, 64'h2100, 64'h0, 64'h11, 64'h11, 64'h0, 0, 2, 1, 0));
    vecs.push_back(mk("sc_d_addr_miss", 0, SWAP, 0, 1, D, 64'h2108, 64'h1, 64'h0, 64'h1, 64'h0, 0, 1, 0, 0));
    vecs.push_back(mk("sc_d_after_miss", 0, SWAP, 0, 1, D, 64'h2100, 64'h1, 64'h0, 64'h1, 64'h0, 0, 1, 0, 0));
    v = mk("lr_d_clr_wins", 0, SWAP, 1, 0, D, 64'h2200, 64'h0, 64'h22, 64'h22, 64'h0, 0, 2, 1, 0);
    v.clr = 1'b1; vecs.push_back(v);
    vecs.push_back(mk("sc_d_after_clr", 0, SWAP, 0, 1, D, 64'h2200, 64'h5, 64'h0, 64'h1, 64'h0, 0, 1, 0, 0));
    vecs.push_back(mk("lr_d_2300", 0, SWAP, 1, 0, D, 64'h2300, 64'h0, 64'h33, 64'h33, 64'h0, 0, 2, 1, 0));
    v = mk("sc_d_clr_in_wr", 0, SWAP, 0, 1, D, 64'h2300, 64'h99, 64'h0, 64'h0, 64'h99, 0, 2, 0, 1);
    v.clr = 1'b1; vecs.push_back(v);
    vecs.push_back(mk("lr_w_3000", 0, SWAP, 1, 0, W, 64'h3000, 64'h0, 64'h8000_0001,
                      64'hFFFF_FFFF_8000_0001, 64'h0, 0, 2, 1, 0));
    v = mk("sc_w_pulse_clr", 0, SWAP, 0, 1, W, 64'h3000, 64'h7, 64'h0, 64'h1, 64'h0, 0, 1, 0, 0);
    v.pre_clr = 1'b1; vecs.push_back(v);
    vecs.push_back(mk("lr_w_3100", 0, SWAP, 1, 0, W, 64'h3100, 64'h0, 64'h5, 64'h5, 64'h0, 0, 2, 1, 0));
    vecs.push_back(mk("sc_w_ok", 0, SWAP, 0, 1, W, 64'h3100, 64'hFFFF_FFFF_0000_0042, 64'h0,
                      64'h0, 64'h42, 0, 2, 0, 1));
    vecs.push_back(mk("lr_d_2400", 0, SWAP, 1, 0, D, 64'h2400, 64'h0, 64'h44, 64'h44, 64'h0, 0, 2, 1, 0));
    vecs.push_back(mk("sc_d_mis", 0, SWAP, 0, 1, D, 64'h2404, 64'h5, 64'h0, 64'h0, 64'h0, 1, 1, 0, 0));
    vecs.push_back(mk("sc_d_after_mis", 0, SWAP, 0, 1, D, 64'h2400, 64'h5, 64'h0, 64'h0, 64'h5, 0, 2, 0, 1));
    vecs.push_back(mk("lr_w_mis", 0, SWAP, 1, 0, W, 64'h3002, 64'h0, 64'h0, 64'h0, 64'h0, 1, 1, 0, 0));
    v = mk("amoor_d_backpressure", 1, OR, 0, 0, D, 64'h1800, 64'hF0, 64'h0F, 64'h0F, 64'hFF, 0, 9, 1, 1);
    v.rd_wait = 4; v.wr_wait = 2; v.keep_valid = 1'b1; vecs.push_back(v);

    // Reset state
    #12;
    check("reset.mem_req", mem_req, 1'b0);
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.result", result, 64'h0);
    check("reset.misaligned", misaligned, 1'b0);
    check("reset.mem_addr", mem_addr, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i], r);
      check_vec(vecs[i], r);
    end

    // LR sets a reservation, a reset lands in the middle of an AMO write,
    // and the reservation must not survive the reset.
    v = mk("lr_d_2500", 0, SWAP, 1, 0, D, 64'h2500, 64'h0, 64'h55, 64'h55, 64'h0, 0, 2, 1, 0);
    run_op(v, r);
    check_vec(v, r);

    valid = 1'b1; amo = 1'b1; amo_op = ADD; lr = 1'b0; sc = 1'b0; size = D;
    addr = 64'h1900; rs2 = 64'h1; mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    check("midwr.rd_req", {mem_req, mem_we}, 2'b10);
    mem_ready = 1'b1; mem_rdata = 64'h10;
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    check("midwr.wr_req", {mem_req, mem_we}, 2'b11);
    check("midwr.wdata", mem_wdata, 64'h11);
    #2 rst_n = 1'b0;
    #1;
    check("midwr.req_dropped", mem_req, 1'b0);
    check("midwr.busy", busy, 1'b0);
    check("midwr.we", mem_we, 1'b0);
    check("midwr.wdata_cleared", mem_wdata, 64'h0);
    @(negedge clk);
    check("midwr.busy_in_reset", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    v = mk("sc_d_after_reset", 0, SWAP, 0, 1, D, 64'h2500, 64'h5, 64'h0, 64'h1, 64'h0, 0, 1, 0, 0);
    run_op(v, r);
    check_vec(v, r);
    v = mk("amoadd_d_after_reset", 1, ADD, 0, 0, D, 64'h1A00, 64'h3, 64'h5, 64'h5, 64'h8, 0, 3, 1, 1);
    run_op(v, r);
    check_vec(v, r);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_core_amo_unit.md
Name: riscv_core_amo_unit

Overview:
Execute-stage sequencer for A-extension instructions. It consumes the main decoder's amo/amo_op/lr/sc/size outputs together with the operand values, and runs read-modify-write, LR and SC sequences over a single-outstanding data-memory port. It holds the pipeline while busy and returns the rd value on completion. It also owns the LR/SC reservation register.

Parameters:
- XLEN, 64, data and address width.

Ports:
- i_amo_unit_clk  in  1  core clock.
- i_amo_unit_rst_n  in  1  asynchronous active-low reset.
- i_amo_unit_valid  in  1  start request; sampled only in IDLE.
- i_amo_unit_amo  in  1  read-modify-write AMO.
- i_amo_unit_amo_op  in  4  0 swap, 1 add, 2 and, 3 or, 4 xor, 5 max, 6 min, 7 maxu, 8 minu.
- i_amo_unit_lr  in  1  load-reserved.
- i_amo_unit_sc  in  1  store-conditional.
- i_amo_unit_size  in  2  2'b10 word, 2'b11 doubleword.
- i_amo_unit_addr  in  XLEN  rs1 value.
- i_amo_unit_rs2  in  XLEN  rs2 value.
- i_amo_unit_resv_clr  in  1  invalidate reservation (trap, context switch).
- i_amo_unit_mem_ready  in  1  memory accepts/completes the current request.
- i_amo_unit_mem_rdata  in  XLEN  read data, valid when ready is high on a read.
- o_amo_unit_mem_req  out  1  memory request.
- o_amo_unit_mem_we  out  1  1 = write.
- o_amo_unit_mem_addr  out  XLEN  request address.
- o_amo_unit_mem_wdata  out  XLEN  write data; for word ops the value is in bits [31:0].
- o_amo_unit_mem_size  out  2  equals the latched size.
- o_amo_unit_busy  out  1  stall to the pipeline.
- o_amo_unit_done  out  1  one-cycle completion pulse.
- o_amo_unit_result  out  XLEN  rd writeback value, valid while done is high.
- o_amo_unit_misaligned  out  1  address-misaligned exception, pulses with done.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE and the reservation is cleared.
  - All outputs go to 0, including a mem_req that was mid-transaction.
- States: IDLE, RD, WR, DONE.
  - busy = (state != IDLE).
  - mem_req = (state == RD or WR), driven combinationally from the state.
  - mem_we = (state == WR).
- Accept:
  - In IDLE with valid high, latch op, size, addr and rs2.
  - valid is ignored while busy.
  - valid with none of amo/lr/sc set goes straight to DONE with result 0.
- Alignment:
  - A word op with addr[1:0] != 0, or a doubleword op with addr[2:0] != 0, is misaligned.
  - Misaligned goes IDLE -> DONE with misaligned=1 and result 0.
  - No memory access occurs and the reservation is unchanged.
- Transitions:
  - AMO: IDLE -> RD -> WR -> DONE.
  - LR: IDLE -> RD -> DONE.
  - SC with reservation valid and reserved address == addr: IDLE -> WR -> DONE.
  - SC otherwise: IDLE -> DONE.
  - DONE -> IDLE unconditionally.
- Memory handshake:
  - In RD and WR, req, addr, we, wdata and size are held stable until ready is sampled high.
  - The state advances on that edge; there is no timeout.
- Read capture:
  - On the RD-completing edge, capture the load value L.
  - Word: L = sign-extended rdata[31:0]. Doubleword: L = rdata.
- Modify (registered on the same edge):
  - Operand B = rs2, using the low 32 bits for word ops.
  - add uses modulo-2^32 or 2^64 arithmetic.
  - max/min compare signed and maxu/minu compare unsigned, at operation width.
  - swap writes B.
  - Word writes use bits [31:0].
- Results:
  - AMO and LR: result = L.
  - SC: result 0 on success, 1 on failure.
- Reservation:
  - LR completion sets valid=1 and stores addr.
  - Any SC clears the reservation, pass or fail.
  - resv_clr clears it at any time.
  - If resv_clr coincides with an LR setting the reservation, the clear wins.
  - A resv_clr arriving while an SC is in WR does not abort the committed write.
- Minimum latency (ready always high, start accepted at cycle 0): done pulses at
  - AMO: cycle 3.
  - LR and SC success: cycle 2.
  - SC failure and misaligned: cycle 1.

Test Plan:
- AMOADD.D: addr 0x1000, mem 0x5, rs2 0x3, ready always 1 -> read 0x1000, then write 0x8; result 0x5; done at cycle 3.
- AMOMIN.W vs AMOMINU.W: mem word 0xFFFFFFFF, rs2 0x1.
  - Signed: writes 0xFFFFFFFF; result 0xFFFFFFFFFFFFFFFF.
  - Unsigned: writes 0x1.
- LR.D 0x2000 then SC.D 0x2000 with rs2 0xAB:
  - Write of 0xAB; result 0; reservation cleared.
  - A second SC.D 0x2000 performs no memory access and returns result 1.
- LR.W 0x3000, then resv_clr pulse, then SC.W 0x3000 -> no write; result 1.
- AMOSWAP.D at 0x1004 -> misaligned=1 and done at cycle 1; mem_req never asserted.
- Backpressure:
  - AMOOR.D with ready low 4 cycles in RD and 2 in WR -> req, addr and wdata stable throughout; done at cycle 9.
  - Reset asserted mid-WR -> req drops immediately; busy=0.
